// File: rtl/psi_pkg.sv
// Shared definitions for the parallel sequence insertion/detection pair:
// FSM state encodings and the accumulator sizing rule.
package psi_pkg;

  typedef enum logic [1:0] {
    STS_Idle   = 2'b00,
    STS_Active = 2'b01,
    STS_Drain  = 2'b10
  } psi_state_e;

  // Accumulator must hold a partial word plus a full incoming word, or the
  // whole pattern sitting at the largest offset.
  function automatic int unsigned acc_width(input int unsigned wid_bitstream,
                                            input int unsigned wid_compair);
    int unsigned two_w;
    int unsigned c_w;
    two_w = 2 * wid_bitstream;
    c_w   = wid_compair + wid_bitstream;
    return (two_w > c_w) ? two_w : c_w;
  endfunction

endpackage

// File: rtl/parallel_sequence_insertion.sv
// Builds a frame (sync pattern at a bit offset, then payload words) as an
// LSB-first bitstream and emits it as registered parallel words.
module parallel_sequence_insertion
  import psi_pkg::*;
#(
  parameter int unsigned WID_Bitstream = 8,
  parameter int unsigned WID_Compair   = 12,
  parameter int unsigned WID_Length    = 16
) (
  input  logic                             local_PSI_clk,
  input  logic                             local_PSI_reset,
  input  logic                             local_PSI_newframe,
  input  logic [WID_Compair-1:0]           local_PSI_pattern,
  input  logic [$clog2(WID_Bitstream)-1:0] local_PSI_offset,
  input  logic [WID_Length-1:0]            local_PSI_length,
  input  logic [WID_Bitstream-1:0]         local_PSI_data,
  input  logic                             local_PSI_valid,
  output logic                             PSI_local_ready,
  output logic                             PSI_local_busy,
  output logic [WID_Bitstream-1:0]         PSI_local_bitstream,
  output logic                             PSI_local_strobe,
  output logic                             PSI_local_last
);

  localparam int unsigned AccW  = acc_width(WID_Bitstream, WID_Compair);
  localparam int unsigned FillW = $clog2(AccW + 1);
  localparam logic [FillW-1:0] WFill = FillW'(WID_Bitstream);

  psi_state_e              state_q, state_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [FillW-1:0]        fill_q, fill_d;
  logic [WID_Length-1:0]   remaining_q, remaining_d;
  logic [WID_Bitstream-1:0] bitstream_q;
  logic                    strobe_q, last_q;

  logic                    emit;
  logic                    ready;
  logic                    accept;
  logic                    last;
  logic [AccW-1:0]         acc_sh;
  logic [FillW-1:0]        fill_after;
  logic [WID_Bitstream-1:0] word;

  // State and datapath registers.
  always_ff @(posedge local_PSI_clk or negedge local_PSI_reset) begin
    if (!local_PSI_reset) begin
      state_q     <= STS_Idle;
      acc_q       <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      bitstream_q <= '0;
      strobe_q    <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      strobe_q    <= emit;
      last_q      <= last;
      if (emit) begin
        bitstream_q <= word;
      end
    end
  end

  // Emit/accept decisions; depend only on registers plus the valid input.
  always_comb begin
    emit       = 1'b0;
    acc_sh     = acc_q;
    fill_after = fill_q;
    word       = '0;
    if (state_q == STS_Active || state_q == STS_Drain) begin
      emit = (fill_q >= WFill) || (state_q == STS_Drain && fill_q != '0);
      if (emit) begin
        acc_sh     = acc_q >> WID_Bitstream;
        fill_after = (fill_q >= WFill) ? fill_q - WFill : '0;
        // Bits above fill are zero by construction; masking keeps it explicit.
        word       = acc_q[WID_Bitstream-1:0] & ~({WID_Bitstream{1'b1}} << fill_q);
      end
    end
    ready  = (state_q == STS_Active) && (fill_after < WFill);
    accept = ready && local_PSI_valid;
    last   = emit && (state_q == STS_Drain) && (fill_after == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    case (state_q)
      STS_Idle: begin
        if (local_PSI_newframe) begin
          acc_d       = AccW'(local_PSI_pattern) << local_PSI_offset;
          fill_d      = FillW'(local_PSI_offset) + FillW'(WID_Compair);
          remaining_d = local_PSI_length;
          state_d     = (local_PSI_length == '0) ? STS_Drain : STS_Active;
        end
      end
      STS_Active: begin
        acc_d  = acc_sh;
        fill_d = fill_after;
        if (accept) begin
          acc_d       = acc_sh | (AccW'(local_PSI_data) << fill_after);
          fill_d      = fill_after + WFill;
          remaining_d = remaining_q - WID_Length'(1);
          if (remaining_q == WID_Length'(1)) begin
            state_d = STS_Drain;
          end
        end
      end
      STS_Drain: begin
        acc_d  = acc_sh;
        fill_d = fill_after;
        if (last) begin
          state_d = STS_Idle;
        end
      end
      default: begin
        state_d     = STS_Idle;
        acc_d       = '0;
        fill_d      = '0;
        remaining_d = '0;
      end
    endcase
  end

  assign PSI_local_ready     = ready;
  assign PSI_local_busy      = (state_q != STS_Idle);
  assign PSI_local_bitstream = bitstream_q;
  assign PSI_local_strobe    = strobe_q;
  assign PSI_local_last      = last_q;

endmodule

// File: tb/tb_parallel_sequence_insertion.sv
// Directed bench for parallel_sequence_insertion: a bit-level frame model
// predicts the word sequence, checked on every strobe.
module tb_parallel_sequence_insertion;

  logic        clk;
  logic        rst_n;
  logic        newframe;
  logic [11:0] pattern;
  logic [2:0]  offset;
  logic [15:0] length;
  logic [7:0]  data;
  logic        valid;
  logic        ready, busy, strobe, last;
  logic [7:0]  bitstream;

  logic        newframe2;
  logic [0:0]  pattern2;
  logic [2:0]  offset2;
  logic [15:0] length2;
  logic [7:0]  data2;
  logic        valid2;
  logic        ready2, busy2, strobe2, last2;
  logic [7:0]  bitstream2;

  int total = 0;
  int bad   = 0;

  logic [7:0] feed_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int  acc_cnt    = 0;
  int  stall_at   = -1;
  int  stall_left = 0;
  bit  pend       = 0;
  bit  chk_on     = 1;

  parallel_sequence_insertion #(
    .WID_Bitstream(8), .WID_Compair(12), .WID_Length(16)
  ) dut (
    .local_PSI_clk      (clk),
    .local_PSI_reset    (rst_n),
    .local_PSI_newframe (newframe),
    .local_PSI_pattern  (pattern),
    .local_PSI_offset   (offset),
    .local_PSI_length   (length),
    .local_PSI_data     (data),
    .local_PSI_valid    (valid),
    .PSI_local_ready    (ready),
    .PSI_local_busy     (busy),
    .PSI_local_bitstream(bitstream),
    .PSI_local_strobe   (strobe),
    .PSI_local_last     (last)
  );

  parallel_sequence_insertion #(
    .WID_Bitstream(8), .WID_Compair(1), .WID_Length(16)
  ) dut2 (
    .local_PSI_clk      (clk),
    .local_PSI_reset    (rst_n),
    .local_PSI_newframe (newframe2),
    .local_PSI_pattern  (pattern2),
    .local_PSI_offset   (offset2),
    .local_PSI_length   (length2),
    .local_PSI_data     (data2),
    .local_PSI_valid    (valid2),
    .PSI_local_ready    (ready2),
    .PSI_local_busy     (busy2),
    .PSI_local_bitstream(bitstream2),
    .PSI_local_strobe   (strobe2),
    .PSI_local_last     (last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: lay out offset zeros, pattern bits, payload bits LSB-first,
  // pad to a whole word and cut into bytes.
  task automatic model_frame(input int off, input logic [11:0] pat, input int cw,
                             input int len);
    bit         bq[$];
    logic [7:0] w;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < off; i++) bq.push_back(1'b0);
    for (int i = 0; i < cw; i++) bq.push_back(pat[i]);
    for (int j = 0; j < len; j++)
      for (int b = 0; b < 8; b++) bq.push_back(feed_q[j][b]);
    while (bq.size() % 8 != 0) bq.push_back(1'b0);
    for (int k = 0; k < bq.size(); k += 8) begin
      for (int b = 0; b < 8; b++) w[b] = bq[k + b];
      exp_q.push_back(w);
    end
  endtask

  task automatic start_frame(input int off, input logic [11:0] pat, input int len);
    acc_cnt = 0;
    model_frame(off, pat, 12, len);
    @(negedge clk);
    newframe = 1'b1;
    pattern  = pat;
    offset   = 3'(off);
    length   = 16'(len);
    @(negedge clk);
    newframe = 1'b0;
  endtask

  task automatic wait_done(output int gaps);
    int i;
    gaps = 0;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) break;
      if (!strobe && got_q.size() > 0) gaps++;
    end
    check("frame_done", exp_q.size(), 0);
    check("idle_after", busy, 0);
  endtask

  task automatic check_got(input string name, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3, input int n);
    logic [7:0] ref_w[4];
    ref_w = '{w0, w1, w2, w3};
    check({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) check(name, got_q[i], ref_w[i]);
  endtask

  // Payload driver: presents feed_q words, with an optional stall window.
  always @(negedge clk) begin
    logic [7:0] tmp;
    if (pend && feed_q.size() > 0) begin
      tmp = feed_q.pop_front();
      acc_cnt++;
    end
    pend = 0;
    if (feed_q.size() > 0 && !(acc_cnt == stall_at && stall_left > 0)) begin
      valid = 1'b1;
      data  = feed_q[0];
    end else begin
      valid = 1'b0;
      if (feed_q.size() > 0 && busy) begin
        stall_left--;
        check("ready_in_stall", ready, 1);
      end
    end
    pend = valid && ready;
  end

  // Compare every strobe against the model.
  always @(negedge clk) begin
    logic [7:0] w;
    if (rst_n && chk_on) begin
      if (strobe) begin
        if (exp_q.size() == 0) check("extra_strobe", strobe, 0);
        else begin
          w = exp_q.pop_front();
          check("word", bitstream, w);
          check("last", last, (exp_q.size() == 0));
          got_q.push_back(bitstream);
        end
      end else if (last) begin
        check("last_no_strobe", last, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int gaps;
    logic [7:0] w2q[$];
    logic       l2q[$];
    rst_n = 1'b0; newframe = 1'b0; pattern = '0; offset = '0; length = '0;
    data = '0; valid = 1'b0;
    newframe2 = 1'b0; pattern2 = '0; offset2 = '0; length2 = '0; data2 = '0; valid2 = 1'b0;
    #12;
    check("rst_bitstream", bitstream, 0);
    check("rst_strobe", strobe, 0);
    check("rst_last", last, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Offset 0, no payload.
    start_frame(0, 12'hA5C, 0);
    wait_done(gaps);
    check_got("t1_word", 8'h5C, 8'h0A, 8'h00, 8'h00, 2);

    // Offset 3, two payload words, valid held: consecutive strobes from cycle 2.
    feed_q = '{8'h11, 8'h22};
    start_frame(3, 12'hA5C, 2);
    check("t2_exp_words", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'hE0D20811);
    check("t2_busy_c1", busy, 1);
    check("t2_strobe_c1", strobe, 0);
    check("t2_ready_c1", ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_no_gap", strobe, 1);
    end
    wait_done(gaps);
    check_got("t2_word", 8'hE0, 8'hD2, 8'h08, 8'h11, 4);

    // Same frame with a 3-cycle upstream stall before the second word.
    feed_q = '{8'h11, 8'h22};
    stall_at = 1; stall_left = 3;
    start_frame(3, 12'hA5C, 2);
    wait_done(gaps);
    check("t3_gaps_seen", (gaps > 0), 1);
    check_got("t3_word", 8'hE0, 8'hD2, 8'h08, 8'h11, 4);
    stall_at = -1;

    // newframe pulsed mid-frame (cycle 2) and on the Drain exit cycle (cycle 4).
    feed_q = '{8'h11, 8'h22};
    start_frame(3, 12'hA5C, 2);
    @(negedge clk);
    newframe = 1'b1; pattern = 12'hFFF; offset = 3'd0; length = 16'd5;
    @(negedge clk);
    newframe = 1'b0;
    @(negedge clk);
    newframe = 1'b1;
    @(negedge clk);
    newframe = 1'b0;
    wait_done(gaps);
    check_got("t4_word", 8'hE0, 8'hD2, 8'h08, 8'h11, 4);
    repeat (3) @(negedge clk);
    check("t4_stays_idle", busy, 0);

    // Asynchronous reset after the second word, then a fresh frame.
    feed_q = '{8'h11, 8'h22};
    start_frame(3, 12'hA5C, 2);
    for (int i = 0; i < 20 && got_q.size() < 2; i++) begin
      @(negedge clk);
      #1;
    end
    check("t5_two_words", got_q.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_bitstream", bitstream, 0);
    check("t5_rst_strobe", strobe, 0);
    check("t5_rst_last", last, 0);
    check("t5_rst_ready", ready, 0);
    check("t5_rst_busy", busy, 0);
    feed_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    feed_q = '{8'h33};
    start_frame(0, 12'hA5C, 1);
    wait_done(gaps);
    check_got("t5_word", 8'h5C, 8'h3A, 8'h03, 8'h00, 3);

    // Single-bit pattern at offset W-1.
    @(negedge clk);
    newframe2 = 1'b1; pattern2 = 1'b1; offset2 = 3'd7; length2 = 16'd1;
    data2 = 8'h5A; valid2 = 1'b1;
    @(negedge clk);
    newframe2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (strobe2) begin
        w2q.push_back(bitstream2);
        l2q.push_back(last2);
      end
      @(negedge clk);
    end
    valid2 = 1'b0;
    check("t6_count", w2q.size(), 2);
    if (w2q.size() >= 2) begin
      check("t6_word0", w2q[0], 8'h80);
      check("t6_word1", w2q[1], 8'h5A);
      check("t6_last0", l2q[0], 0);
      check("t6_last1", l2q[1], 1);
    end
    check("t6_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
